// File: rtl/leading_one_decode_if.sv
// Handshake bundle between the leading-one index producer and the decoder.
// The decoder takes the slave view; the upstream/downstream side takes master.
interface leading_one_decode_if #(
  parameter int WIDTH = 9,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_index;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_onehot;
  logic [WIDTH-1:0] out_mask;
  logic             out_zero;
  logic             out_err;
  logic             err_sticky;
  logic             err_clr;
  logic [CNT_W-1:0] dec_count;

  modport slave (
    input  in_valid, in_index, out_ready, err_clr,
    output in_ready, out_valid, out_onehot, out_mask, out_zero, out_err,
           err_sticky, dec_count
  );

  modport master (
    output in_valid, in_index, out_ready, err_clr,
    input  in_ready, out_valid, out_onehot, out_mask, out_zero, out_err,
           err_sticky, dec_count
  );
endinterface

// File: rtl/leading_one_decode.sv
// Regenerates one-hot and thermometer mask from a signed leading-one index,
// buffered through a 2-entry FIFO whose head slot drives the outputs directly.
module leading_one_decode #(
  parameter int WIDTH = 9,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  leading_one_decode_if.slave  bus
);
  localparam int EW = 2 * WIDTH + 2;

  // Entry layout: {onehot, mask, zero, err}; unused slots are kept all-zero.
  function automatic logic [EW-1:0] decode_entry(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] mask;
    logic             zero;
    logic             err;
    logic [31:0]      iv;
    iv     = 32'(idx);
    onehot = {WIDTH{1'b0}};
    mask   = {WIDTH{1'b0}};
    zero   = 1'b0;
    err    = 1'b0;
    if (idx == {IDX_W{1'b1}}) begin
      zero = 1'b1;
    end else if (iv < 32'(WIDTH)) begin
      // Bitwise compare keeps the mask inside WIDTH even at the top index.
      for (int b = 0; b < WIDTH; b++) begin
        onehot[b] = (iv == 32'(b));
        mask[b]   = (32'(b) <= iv);
      end
    end else begin
      err = 1'b1;
    end
    return {onehot, mask, zero, err};
  endfunction

  logic [EW-1:0]    e0_r, e1_r, e0_s, e1_s, new_s;
  logic             v0_r, v1_r, v0_s, v1_s;
  logic             rdy_r;
  logic             sticky_r, sticky_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             in_ready_s, push_s, pop_s;

  // Slot 0 is the head; the buffer is full exactly when slot 1 is occupied.
  assign in_ready_s = rdy_r && !v1_r;

  // Next-state for the buffer slots, error flag and delivered counter.
  always_comb begin
    new_s    = decode_entry(bus.in_index);
    push_s   = bus.in_valid && in_ready_s;
    pop_s    = v0_r && bus.out_ready;
    e0_s     = e0_r;
    e1_s     = e1_r;
    v0_s     = v0_r;
    v1_s     = v1_r;
    sticky_s = sticky_r;
    cnt_s    = cnt_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (!v0_r) begin
          e0_s = new_s;
          v0_s = 1'b1;
        end else begin
          e1_s = new_s;
          v1_s = 1'b1;
        end
      end
      2'b01: begin
        e0_s = e1_r;
        v0_s = v1_r;
        e1_s = {EW{1'b0}};
        v1_s = 1'b0;
      end
      2'b11: begin
        e0_s = v1_r ? e1_r : new_s;
        v0_s = 1'b1;
        e1_s = v1_r ? new_s : {EW{1'b0}};
        v1_s = v1_r;
      end
      default: begin
        e0_s = e0_r;
        e1_s = e1_r;
      end
    endcase
    if (push_s && new_s[0]) begin
      sticky_s = 1'b1;
    end else if (bus.err_clr) begin
      sticky_s = 1'b0;
    end else begin
      sticky_s = sticky_r;
    end
    if (pop_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State registers; rdy_r holds off acceptance until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_r     <= {EW{1'b0}};
      e1_r     <= {EW{1'b0}};
      v0_r     <= 1'b0;
      v1_r     <= 1'b0;
      rdy_r    <= 1'b0;
      sticky_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      e0_r     <= e0_s;
      e1_r     <= e1_s;
      v0_r     <= v0_s;
      v1_r     <= v1_s;
      rdy_r    <= 1'b1;
      sticky_r <= sticky_s;
      cnt_r    <= cnt_s;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = v0_r;
  assign bus.out_onehot = e0_r[EW-1 -: WIDTH];
  assign bus.out_mask   = e0_r[WIDTH+1 -: WIDTH];
  assign bus.out_zero   = e0_r[1];
  assign bus.out_err    = e0_r[0];
  assign bus.err_sticky = sticky_r;
  assign bus.dec_count  = cnt_r;
endmodule
